// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32 constants, field positions and fetch FSM encoding.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fields.sv
`default_nettype none
// ============================================================================
// Module   : instr_fields
// Brief    : Pure slicer of a 32-bit RV32 instruction into its fixed fields.
// Revision : 1.0
// ============================================================================
module instr_fields
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [6:0]  funct7_o
);

  assign opcode_o = instr_i[OPCODE_MSB:OPCODE_LSB];
  assign rd_o     = instr_i[RD_MSB:RD_LSB];
  assign funct3_o = instr_i[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1_o    = instr_i[RS1_MSB:RS1_LSB];
  assign rs2_o    = instr_i[RS2_MSB:RS2_LSB];
  assign funct7_o = instr_i[FUNCT7_MSB:FUNCT7_LSB];

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Single-outstanding instruction fetch stage with redirect/stall.
// Revision : 1.0
// ============================================================================
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic            fetch_misaligned
);

  if (XLEN != 32) begin : g_xlen_check
    $error("ifetch_unit supports XLEN=32 only");
  end

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            drop_q, drop_d;
  logic            mis_q, mis_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    mis_d      = mis_q;

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          req_pc_d = fetch_pc_q;
          state_d  = S_WAIT;
          // The accepted request is now stale; its response must be eaten.
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rsp_data;
            pc_d    = req_pc_q;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d    = 1'b0;
          fetch_pc_d = pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      mis_d      = |redirect_pc[1:0];
    end
  end

  // Gated by rst_n so no request is advertised while reset is held.
  assign imem_req_valid   = (state_q == S_REQ) && rst_n;
  assign imem_req_addr    = fetch_pc_q;
  assign instr_valid      = valid_q;
  assign instr            = instr_q;
  assign pc               = pc_q;
  assign fetch_misaligned = mis_q;

  instr_fields u_instr_fields (
    .instr_i  (instr_q),
    .opcode_o (opcode),
    .rd_o     (rd),
    .funct3_o (funct3),
    .rs1_o    (rs1),
    .rs2_o    (rs2),
    .funct7_o (funct7)
  );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Directed table-driven bench for ifetch_unit (RESET_PC=0x100).
// Revision : 1.0
// ============================================================================
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] I0     = 32'h0050_0093;
  localparam logic [31:0] I1     = 32'h0020_81B3;
  localparam logic [31:0] I2     = 32'h0000_0013;
  localparam logic [31:0] I3     = 32'h00A0_0093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic        fetch_misaligned;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stall            (stall),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .pc               (pc),
    .opcode           (opcode),
    .rd               (rd),
    .funct3           (funct3),
    .rs1              (rs1),
    .rs2              (rs2),
    .funct7           (funct7),
    .fetch_misaligned (fetch_misaligned)
  );

  typedef struct {
    logic        ready;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        rdr_v;
    logic [31:0] rdr_pc;
    logic        stall;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic ready, input logic rsp_v, input logic [31:0] rsp_d,
                              input logic rdr_v, input logic [31:0] rdr_pc, input logic st,
                              input logic e_reqv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_mis);
    vec_t v;
    v.ready = ready; v.rsp_v = rsp_v; v.rsp_d = rsp_d; v.rdr_v = rdr_v;
    v.rdr_pc = rdr_pc; v.stall = st; v.e_reqv = e_reqv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_pc = e_pc; v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic drive(input logic ready, input logic rsp_v, input logic [31:0] rsp_d,
                       input logic rdr_v, input logic [31:0] rdr_pc, input logic st);
    imem_req_ready = ready;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_d;
    redirect_valid = rdr_v;
    redirect_pc    = rdr_pc;
    stall          = st;
  endtask

  initial begin
    // ready rspv data  rdr addr stall | reqv addr iv pc instr mis
    vecs.push_back(mk(1,0,0,0,0,0,            1,32'h100,0,32'h100,NOP,0)); // 0
    vecs.push_back(mk(0,1,I0,0,0,0,           0,0,0,32'h100,NOP,0));       // 1
    vecs.push_back(mk(0,0,0,0,0,1,            0,0,1,32'h100,I0,0));        // 2
    vecs.push_back(mk(0,1,32'hDEADBEEF,0,0,1, 0,0,1,32'h100,I0,0));        // 3
    vecs.push_back(mk(0,0,0,0,0,1,            0,0,1,32'h100,I0,0));        // 4
    vecs.push_back(mk(0,0,0,0,0,1,            0,0,1,32'h100,I0,0));        // 5
    vecs.push_back(mk(0,0,0,0,0,0,            0,0,1,32'h100,I0,0));        // 6
    vecs.push_back(mk(0,0,0,0,0,0,            1,32'h104,0,32'h100,I0,0));  // 7
    vecs.push_back(mk(0,0,0,0,0,0,            1,32'h104,0,32'h100,I0,0));  // 8
    vecs.push_back(mk(1,0,0,1,32'h500,0,      1,32'h104,0,32'h100,I0,0));  // 9
    vecs.push_back(mk(0,1,32'h11111111,0,0,0, 0,0,0,32'h100,I0,0));        // 10
    vecs.push_back(mk(1,0,0,0,0,0,            1,32'h500,0,32'h100,I0,0));  // 11
    vecs.push_back(mk(0,0,0,1,32'h200,0,      0,0,0,32'h100,I0,0));        // 12
    vecs.push_back(mk(0,0,0,0,0,0,            0,0,0,32'h100,I0,0));        // 13
    vecs.push_back(mk(0,0,0,0,0,0,            0,0,0,32'h100,I0,0));        // 14
    vecs.push_back(mk(0,1,32'h22222222,0,0,0, 0,0,0,32'h100,I0,0));        // 15
    vecs.push_back(mk(1,0,0,0,0,0,            1,32'h200,0,32'h100,I0,0));  // 16
    vecs.push_back(mk(0,1,I1,0,0,0,           0,0,0,32'h100,I0,0));        // 17
    vecs.push_back(mk(0,0,0,0,0,0,            0,0,1,32'h200,I1,0));        // 18
    vecs.push_back(mk(0,0,0,1,32'h302,0,      1,32'h204,0,32'h200,I1,0));  // 19
    vecs.push_back(mk(0,0,0,0,0,0,            1,32'h300,0,32'h200,I1,1));  // 20
    vecs.push_back(mk(0,0,0,1,32'h400,0,      1,32'h300,0,32'h200,I1,1));  // 21
    vecs.push_back(mk(1,0,0,0,0,0,            1,32'h400,0,32'h200,I1,0));  // 22
    vecs.push_back(mk(0,0,0,1,32'hFFFFFFFC,0, 0,0,0,32'h200,I1,0));        // 23
    vecs.push_back(mk(0,1,32'h33333333,0,0,0, 0,0,0,32'h200,I1,0));        // 24
    vecs.push_back(mk(1,0,0,0,0,0,            1,32'hFFFFFFFC,0,32'h200,I1,0)); // 25
    vecs.push_back(mk(0,1,I2,0,0,0,           0,0,0,32'h200,I1,0));        // 26
    vecs.push_back(mk(0,0,0,0,0,0,            0,0,1,32'hFFFFFFFC,I2,0));   // 27
    vecs.push_back(mk(1,0,0,0,0,0,            1,32'h0,0,32'hFFFFFFFC,I2,0)); // 28
    vecs.push_back(mk(0,1,I3,0,0,0,           0,0,0,32'hFFFFFFFC,I2,0));   // 29
    vecs.push_back(mk(0,0,0,1,32'h600,1,      0,0,1,32'h0,I3,0));          // 30
    vecs.push_back(mk(1,0,0,0,0,0,            1,32'h600,0,32'h0,I3,0));    // 31

    // Reset values while rst_n is held low.
    #12;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RST_PC);
    chk("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].ready, vecs[i].rsp_v, vecs[i].rsp_d, vecs[i].rdr_v, vecs[i].rdr_pc,
            vecs[i].stall);
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_reqv});
      if (vecs[i].e_reqv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_iv});
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("v%0d_misaligned", i), {31'd0, fetch_misaligned}, {31'd0, vecs[i].e_mis});
      if (i == 2) begin
        chk("addi_opcode", {25'd0, opcode}, 32'h13);
        chk("addi_rd", {27'd0, rd}, 32'd1);
        chk("addi_rs1", {27'd0, rs1}, 32'd0);
        chk("addi_funct3", {29'd0, funct3}, 32'd0);
      end
      if (i == 18) begin
        chk("add_opcode", {25'd0, opcode}, 32'h33);
        chk("add_rd", {27'd0, rd}, 32'd3);
        chk("add_rs1", {27'd0, rs1}, 32'd1);
        chk("add_rs2", {27'd0, rs2}, 32'd2);
        chk("add_funct7", {25'd0, funct7}, 32'd0);
      end
    end

    // Reset asserted mid-S_WAIT, then a late response must be ignored.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_instr", instr, NOP);
    chk("async_rst_pc", pc, RST_PC);
    chk("async_rst_iv", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("async_rst_addr", imem_req_addr, RST_PC);

    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 32'h44444444, 0, 0, 0);
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_req_addr, RST_PC);

    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("late_rsp_iv", {31'd0, instr_valid}, 32'd0);
    chk("late_rsp_instr", instr, NOP);
    chk("late_rsp_addr", imem_req_addr, RST_PC);

    @(negedge clk);
    drive(0, 1, I0, 0, 0, 0);
    #1;
    chk("refetch_req_valid", {31'd0, imem_req_valid}, 32'd0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("refetch_iv", {31'd0, instr_valid}, 32'd1);
    chk("refetch_pc", pc, RST_PC);
    chk("refetch_instr", instr, I0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of ControlUnit.
- Holds the PC and issues one request at a time to instruction memory over a valid/ready request channel with a variable-latency response.
- Latches the returned word into an instruction register and presents the sliced fields (opcode, funct3, funct7, rs1, rs2, rd) to ControlUnit and the register file.
- Accepts taken-branch redirects from the execute side and honours a downstream stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/instruction width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; reload PC.
- redirect_pc  in  32  redirect target.
- stall  in  1  downstream cannot consume the current instruction.
- instr_valid  out  1  instr/pc/fields are valid.
- instr  out  32  instruction register.
- pc  out  32  PC of instr.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- fetch_misaligned  out  1  last redirect target had nonzero bits [1:0].

Behaviour:
- Reset (asynchronous, rst_n=0): state=S_REQ, fetch_pc=RESET_PC, instr=32'h0000_0013 (NOP), pc=RESET_PC, instr_valid=0, drop=0, fetch_misaligned=0, imem_req_valid=0 during reset.
- Field outputs are combinational slices of the instr register. They hold the last value when instr_valid=0.
- FSM states and transitions:
  - S_REQ: imem_req_valid=1, imem_req_addr=fetch_pc. On imem_req_ready=1, req_pc<=fetch_pc and go to S_WAIT.
  - S_WAIT: imem_req_valid=0. On imem_rsp_valid=1:
    - if drop=1: discard the word, drop<=0, go to S_REQ.
    - else: instr<=imem_rsp_data, pc<=req_pc, instr_valid<=1, go to S_VALID.
  - S_VALID: instr_valid=1. Outputs are held stable while stall=1. When stall=0: instr_valid<=0, fetch_pc<=pc+4, go to S_REQ.
- Latency: the first instr_valid comes 2 cycles after the request is accepted with a 1-cycle memory. Steady-state throughput is 1 instruction per 3 cycles at zero wait states.
- PC arithmetic: modulo 2^32. pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Redirect (highest priority, any state):
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - fetch_misaligned<=|redirect_pc[1:0]; this flag holds until the next redirect.
  - In S_REQ with imem_req_ready=1 in the same cycle: the request counts as issued, so go to S_WAIT with drop<=1.
  - In S_REQ without imem_req_ready: stay in S_REQ; the new address appears on the next cycle.
  - In S_WAIT: drop<=1. If imem_rsp_valid arrives in the same cycle, discard it and go to S_REQ with drop<=0.
  - In S_VALID: instr_valid<=0 and go to S_REQ, regardless of stall.
- imem_rsp_valid outside S_WAIT is ignored.
- imem_req_addr and imem_req_valid are stable while waiting for ready.
- At most one outstanding request exists at any time.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_LUI=7'b0110111, OP_BRANCH=7'b1100011);
  - NOP encoding 32'h0000_0013;
  - instruction field bit positions;
  - FSM state encoding (S_REQ, S_WAIT, S_VALID, 2 bits).
- Natural sub-module: instr_fields, a pure slicer from 32-bit instr to opcode/rd/funct3/rs1/rs2/funct7. ControlUnit's future wrapper reuses it.

Test Plan:
- Reset with RESET_PC=32'h100 and memory returning 32'h00500093 after 1 cycle -> imem_req_addr=32'h100 on the first post-reset cycle; instr_valid=1, pc=32'h100, opcode=7'b0010011, rd=1, rs1=0 two cycles after accept.
- Stall held 4 cycles in S_VALID -> instr/pc unchanged and no imem_req_valid; after release the next request goes to 32'h104.
- Redirect to 32'h200 while in S_WAIT, response arriving 3 cycles later -> that word is discarded; the next request addr is 32'h200; the first valid pc is 32'h200.
- Redirect in the same cycle as a request handshake at 32'h104 -> the response for 32'h104 is dropped; the next fetch is the redirect target.
- Redirect to 32'h302 -> imem_req_addr=32'h300 and fetch_misaligned=1; a subsequent redirect to 32'h400 clears it.
- PC at 32'hFFFF_FFFC, stall=0 -> next request addr 32'h0000_0000.
- rst_n asserted mid-S_WAIT -> outputs immediately at reset values; a late imem_rsp_valid after release is ignored; the first request is at RESET_PC.
